// File: rtl/shift_ex_stage.sv
// Two-stage RV32I shift execute unit: stage 1 decodes and registers shift controls,
// stage 2 runs the combinational shifter and registers result, rd and illegal flag.

module shifter #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] operand,
  input  logic [4:0]      shamt,
  input  logic            shift_right,
  input  logic            shift_arith,
  output logic [XLEN-1:0] result
);
  always_comb begin
    if (!shift_right)
      result = operand << shamt;
    else if (shift_arith)
      result = XLEN'($signed(operand) >>> shamt);
    else
      result = operand >> shamt;
  end
endmodule

module shift_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_illegal,
  output logic [31:0]     out_count
);
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_REG = 7'b0110011;

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; the producer holds valid and payload stable until that edge.

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] f7;
  logic       unused_bits;

  assign opcode      = in_instr[6:0];
  assign funct3      = in_instr[14:12];
  assign f7          = in_instr[31:25];
  assign unused_bits = ^{in_rs2_val[XLEN-1:5], in_instr[19:15]};

  logic       legal_fn;
  logic       dec_legal;
  logic [4:0] dec_shamt;
  logic       dec_right;
  logic       dec_arith;

  always_comb begin
    legal_fn = 1'b0;
    case (funct3)
      3'b001:  legal_fn = (f7 == 7'b0000000);
      3'b101:  legal_fn = (f7 == 7'b0000000) || (f7 == 7'b0100000);
      default: legal_fn = 1'b0;
    endcase
    dec_legal = ((opcode == OP_IMM) || (opcode == OP_REG)) && legal_fn;
    dec_shamt = (opcode == OP_REG) ? in_rs2_val[4:0] : in_instr[24:20];
    dec_right = funct3[2];
    // Arithmetic only makes sense for right shifts.
    dec_arith = funct3[2] & f7[5];
  end

  logic            s1_v;
  logic [XLEN-1:0] s1_operand;
  logic [4:0]      s1_shamt;
  logic            s1_right;
  logic            s1_arith;
  logic [4:0]      s1_rd;
  logic            s1_illegal;

  logic            s2_v;
  logic [XLEN-1:0] s2_result;
  logic [4:0]      s2_rd;
  logic            s2_illegal;

  logic            s1_adv;
  logic            s2_adv;
  logic            in_fire;
  logic            s1_move;
  logic            out_fire;
  logic [XLEN-1:0] sh_result;

  assign s2_adv   = !s2_v || out_ready;
  assign s1_adv   = !s1_v || s2_adv;
  assign in_ready = s1_adv && !flush;
  assign in_fire  = in_valid && in_ready;
  assign s1_move  = s1_v && s2_adv && !flush;
  assign out_fire = s2_v && out_ready;

  shifter #(.XLEN(XLEN)) u_shifter (
    .operand     (s1_operand),
    .shamt       (s1_shamt),
    .shift_right (s1_right),
    .shift_arith (s1_arith),
    .result      (sh_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else if (flush) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else begin
      if (s1_adv) s1_v <= in_fire;
      if (s2_adv) s2_v <= s1_v;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_operand <= '0;
      s1_shamt   <= '0;
      s1_right   <= 1'b0;
      s1_arith   <= 1'b0;
      s1_rd      <= '0;
      s1_illegal <= 1'b0;
    end else if (in_fire) begin
      s1_operand <= in_rs1_val;
      s1_shamt   <= dec_shamt;
      s1_right   <= dec_right;
      s1_arith   <= dec_arith;
      s1_rd      <= in_instr[11:7];
      s1_illegal <= !dec_legal;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_result  <= '0;
      s2_rd      <= '0;
      s2_illegal <= 1'b0;
    end else if (s1_move) begin
      s2_result  <= s1_illegal ? '0 : sh_result;
      s2_rd      <= s1_rd;
      s2_illegal <= s1_illegal;
    end
  end

  // A handshake coinciding with flush has already transferred, so it still counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      out_count <= '0;
    else if (out_fire)
      out_count <= out_count + 32'd1;
  end

  assign out_valid   = s2_v;
  assign out_result  = s2_result;
  assign out_rd      = s2_rd;
  assign out_illegal = s2_illegal;
endmodule
